// File: rtl/programmable_sequence_detector_fsm_ctrl.sv
// Control FSM of the programmable sequence detector.
// Holds the programmed pattern and length. Each valid serial bit is compared
// against pattern[count_q], where count_q comes from an external position
// counter. This block drives that counter's enable and its active-low
// synchronous clear, and pulses `detected` when the full pattern matches.
module programmable_sequence_detector_fsm_ctrl #(
    parameter int unsigned SEQ_MAX_LEN = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SEQ_MAX_LEN-1:0] load_pattern,
    input  logic [CNT_W-1:0]       load_length,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic [CNT_W-1:0]       count_q,
    output logic                   counter_enable,
    output logic                   counter_resetnot_sync,
    output logic                   detected,
    output logic                   armed,
    output logic [7:0]             detect_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(SEQ_MAX_LEN);

    state_t                 state_q, state_d;
    logic [SEQ_MAX_LEN-1:0] pattern_q;
    logic [CNT_W-1:0]       length_q, length_d;
    logic                   detected_q, detected_d;
    logic [7:0]             detect_count_q;

    logic                   pat_bit;
    logic                   in_range;
    logic                   last_pos;
    logic                   full_match;

    // Programmed length, clamped to the pattern register size
    assign length_d = (load_length > MAX_LEN) ? MAX_LEN : load_length;

    // Pattern bit at the current counter position; positions beyond the
    // pattern register read as 0 and are rejected by in_range anyway
    always_comb begin
        pat_bit = 1'b0;
        for (int unsigned i = 0; i < SEQ_MAX_LEN; i++) begin
            if (count_q == CNT_W'(i)) begin
                pat_bit = pattern_q[i];
            end
        end
    end

    assign in_range = (count_q < length_q);
    assign last_pos = (count_q == (length_q - CNT_W'(1)));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a load moves between IDLE and ARMED
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (length_d != '0) ? ARMED : IDLE;
        end
    end

    // Counter control and match decode; load overrides any incoming bit
    always_comb begin
        counter_enable        = 1'b0;
        counter_resetnot_sync = 1'b0;
        full_match            = 1'b0;
        if (!load && (state_q == ARMED)) begin
            if (!bit_valid) begin
                counter_resetnot_sync = 1'b1;
            end else if (in_range && (bit_in == pat_bit)) begin
                if (last_pos) begin
                    full_match = 1'b1;
                end else begin
                    counter_enable        = 1'b1;
                    counter_resetnot_sync = 1'b1;
                end
            end else begin
                // Restart: the counter clears, then lands on 1 if this bit
                // can begin a fresh attempt
                counter_enable = (bit_in == pattern_q[0]);
            end
        end
    end

    assign detected_d = full_match;

    // Programmed pattern and length registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            length_q  <= '0;
        end else if (load) begin
            pattern_q <= load_pattern;
            length_q  <= length_d;
        end
    end

    // Detection pulse and saturating detection counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            detected_q     <= 1'b0;
            detect_count_q <= '0;
        end else begin
            detected_q <= detected_d;
            if (full_match && (detect_count_q != 8'hFF)) begin
                detect_count_q <= detect_count_q + 8'd1;
            end
        end
    end

    assign detected     = detected_q;
    assign detect_count = detect_count_q;
    assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_programmable_sequence_detector_fsm_ctrl.sv
// Directed bench for the sequence detector control FSM. Includes a model of
// the external position counter (active-low sync clear, enable; a clear with
// enable high lands on 1).
module tb_programmable_sequence_detector_fsm_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_pattern;
    logic [3:0] load_length;
    logic       bit_valid;
    logic       bit_in;
    logic [3:0] cnt;
    logic       counter_enable;
    logic       counter_resetnot_sync;
    logic       detected;
    logic       armed;
    logic [7:0] detect_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_dc    = 0;

    programmable_sequence_detector_fsm_ctrl #(
        .SEQ_MAX_LEN(8),
        .CNT_W      (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .load                 (load),
        .load_pattern         (load_pattern),
        .load_length          (load_length),
        .bit_valid            (bit_valid),
        .bit_in               (bit_in),
        .count_q              (cnt),
        .counter_enable       (counter_enable),
        .counter_resetnot_sync(counter_resetnot_sync),
        .detected             (detected),
        .armed                (armed),
        .detect_count         (detect_count)
    );

    always #5 clock = ~clock;

    // External position counter model
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!counter_resetnot_sync) begin
            cnt <= {3'b000, counter_enable};
        end else if (counter_enable) begin
            cnt <= cnt + 4'd1;
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len);
        load         = 1'b1;
        load_pattern = pat;
        load_length  = len;
        bit_valid    = 1'b0;
        cycle();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_pattern = '0; load_length = '0;
        bit_valid = 1'b0; bit_in = 1'b0;
        #12;
        total_cnt++; if (detected !== 1'b0) $display("FAIL reset_detected: got %b expected 0", detected); else pass_cnt++;
        total_cnt++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b expected 0", armed); else pass_cnt++;
        total_cnt++; if (detect_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", detect_count); else pass_cnt++;
        @(posedge clock); #1 reset = 1'b0;
        cycle();
        total_cnt++; if (counter_resetnot_sync !== 1'b0 || counter_enable !== 1'b0)
            $display("FAIL idle_ctrl: got rn=%b en=%b expected rn=0 en=0", counter_resetnot_sync, counter_enable); else pass_cnt++;
        bit_valid = 1'b1; bit_in = 1'b1;
        cycle();
        total_cnt++; if (cnt !== 4'd0 || detected !== 1'b0)
            $display("FAIL idle_bit: got cnt=%0d det=%b expected cnt=0 det=0", cnt, detected); else pass_cnt++;
        bit_valid = 1'b0;
    endtask

    // Pattern 1,0,1,1 sent contiguously
    task automatic test_match();
        logic b[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        int   ec[4] = '{1, 2, 3, 0};
        logic ed[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        // load with a valid bit present: the bit must be dropped
        load = 1'b1; load_pattern = 8'b0000_1101; load_length = 4'd4;
        bit_valid = 1'b1; bit_in = 1'b1;
        #1;
        total_cnt++; if (counter_resetnot_sync !== 1'b0 || counter_enable !== 1'b0)
            $display("FAIL load_ctrl: got rn=%b en=%b expected rn=0 en=0", counter_resetnot_sync, counter_enable); else pass_cnt++;
        cycle();
        load = 1'b0; bit_valid = 1'b0;
        total_cnt++; if (armed !== 1'b1 || cnt !== 4'd0)
            $display("FAIL load_armed: got armed=%b cnt=%0d expected armed=1 cnt=0", armed, cnt); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = b[i];
            cycle();
            total_cnt++; if (cnt !== 4'(ec[i]) || detected !== ed[i])
                $display("FAIL match_step%0d: got cnt=%0d det=%b expected cnt=%0d det=%b", i, cnt, detected, ec[i], ed[i]); else pass_cnt++;
        end
        exp_dc = 1;
        bit_valid = 1'b0;
        cycle();
        total_cnt++; if (detected !== 1'b0 || detect_count !== 8'(exp_dc))
            $display("FAIL match_after: got det=%b count=%0d expected det=0 count=%0d", detected, detect_count, exp_dc); else pass_cnt++;
    endtask

    // 1,1,0,1,1: the second 1 restarts at position 1
    task automatic test_restart();
        logic b[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int   ec[5] = '{1, 1, 2, 3, 0};
        logic ed[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = b[i];
            cycle();
            total_cnt++; if (cnt !== 4'(ec[i]) || detected !== ed[i])
                $display("FAIL restart_step%0d: got cnt=%0d det=%b expected cnt=%0d det=%b", i, cnt, detected, ec[i], ed[i]); else pass_cnt++;
        end
        exp_dc++;
        bit_valid = 1'b0;
        cycle();
        total_cnt++; if (detect_count !== 8'(exp_dc))
            $display("FAIL restart_count: got %0d expected %0d", detect_count, exp_dc); else pass_cnt++;
    endtask

    // 1,0,0: third bit mismatches and cannot start a new attempt
    task automatic test_mismatch();
        logic b[3]  = '{1'b1, 1'b0, 1'b0};
        int   ec[3] = '{1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = b[i];
            cycle();
            total_cnt++; if (cnt !== 4'(ec[i]) || detected !== 1'b0)
                $display("FAIL mismatch_step%0d: got cnt=%0d det=%b expected cnt=%0d det=0", i, cnt, detected, ec[i]); else pass_cnt++;
        end
        bit_valid = 1'b0;
        cycle();
        total_cnt++; if (detect_count !== 8'(exp_dc))
            $display("FAIL mismatch_count: got %0d expected %0d", detect_count, exp_dc); else pass_cnt++;
    endtask

    // 1,gap,0,gap,gap,1,gap,1
    task automatic test_gaps();
        logic v[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic b[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   ec[8] = '{1, 1, 2, 2, 2, 3, 3, 0};
        logic ed[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bit_valid = v[i]; bit_in = b[i];
            #1;
            if (!v[i]) begin
                total_cnt++; if (counter_resetnot_sync !== 1'b1 || counter_enable !== 1'b0)
                    $display("FAIL gap_ctrl%0d: got rn=%b en=%b expected rn=1 en=0", i, counter_resetnot_sync, counter_enable); else pass_cnt++;
            end
            cycle();
            total_cnt++; if (cnt !== 4'(ec[i]) || detected !== ed[i])
                $display("FAIL gap_step%0d: got cnt=%0d det=%b expected cnt=%0d det=%b", i, cnt, detected, ec[i], ed[i]); else pass_cnt++;
        end
        exp_dc++;
        bit_valid = 1'b0;
        cycle();
        total_cnt++; if (detected !== 1'b0 || detect_count !== 8'(exp_dc))
            $display("FAIL gap_after: got det=%b count=%0d expected det=0 count=%0d", detected, detect_count, exp_dc); else pass_cnt++;
    endtask

    // length 0 disables; length 1 allows back-to-back detections
    task automatic test_length_zero_one();
        bit_valid = 1'b1; bit_in = 1'b1; cycle();
        bit_in = 1'b0; cycle();
        total_cnt++; if (cnt !== 4'd2) $display("FAIL len0_pre: got cnt=%0d expected 2", cnt); else pass_cnt++;
        do_load(8'b0000_1101, 4'd0);
        total_cnt++; if (armed !== 1'b0 || cnt !== 4'd0)
            $display("FAIL len0_load: got armed=%b cnt=%0d expected armed=0 cnt=0", armed, cnt); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = (i != 2);
            cycle();
            total_cnt++; if (cnt !== 4'd0 || detected !== 1'b0 || armed !== 1'b0)
                $display("FAIL len0_step%0d: got cnt=%0d det=%b armed=%b expected 0 0 0", i, cnt, detected, armed); else pass_cnt++;
        end
        do_load(8'b0000_0001, 4'd1);
        total_cnt++; if (armed !== 1'b1) $display("FAIL len1_load: got armed=%b expected 1", armed); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            cycle();
            exp_dc++;
            total_cnt++; if (detected !== 1'b1 || cnt !== 4'd0 || detect_count !== 8'(exp_dc))
                $display("FAIL len1_step%0d: got det=%b cnt=%0d count=%0d expected det=1 cnt=0 count=%0d", i, detected, cnt, detect_count, exp_dc); else pass_cnt++;
        end
        bit_in = 1'b0; cycle();
        total_cnt++; if (detected !== 1'b0) $display("FAIL len1_zero: got det=%b expected 0", detected); else pass_cnt++;
        bit_valid = 1'b0;
    endtask

    // length 15 clamps to 8: eight 1s needed for a detection
    task automatic test_clamp();
        do_load(8'hFF, 4'd15);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            cycle();
            total_cnt++; if (cnt !== 4'((i + 1) % 8) || detected !== (i == 7))
                $display("FAIL clamp_step%0d: got cnt=%0d det=%b expected cnt=%0d det=%b", i, cnt, detected, (i + 1) % 8, (i == 7)); else pass_cnt++;
        end
        exp_dc++;
        bit_valid = 1'b0;
        cycle();
        total_cnt++; if (detect_count !== 8'(exp_dc))
            $display("FAIL clamp_count: got %0d expected %0d", detect_count, exp_dc); else pass_cnt++;
    endtask

    // 260 detections saturate the counter, then async reset mid-stream
    task automatic test_saturation_reset();
        do_load(8'b0000_0001, 4'd1);
        for (int i = 0; i < 260; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            cycle();
            exp_dc = (exp_dc < 255) ? exp_dc + 1 : 255;
        end
        total_cnt++; if (detect_count !== 8'(exp_dc) || exp_dc != 255)
            $display("FAIL sat_count: got %0d expected %0d", detect_count, 255); else pass_cnt++;
        total_cnt++; if (detected !== 1'b1) $display("FAIL sat_det: got %b expected 1", detected); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (detected !== 1'b0 || armed !== 1'b0 || detect_count !== 8'd0)
            $display("FAIL async_reset: got det=%b armed=%b count=%0d expected 0 0 0", detected, armed, detect_count); else pass_cnt++;
        total_cnt++; if (counter_resetnot_sync !== 1'b0 || counter_enable !== 1'b0)
            $display("FAIL async_reset_ctrl: got rn=%b en=%b expected rn=0 en=0", counter_resetnot_sync, counter_enable); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        cycle();
        cycle();
        total_cnt++; if (detected !== 1'b0 || armed !== 1'b0 || cnt !== 4'd0 || detect_count !== 8'd0)
            $display("FAIL post_reset: got det=%b armed=%b cnt=%0d count=%0d expected 0 0 0 0", detected, armed, cnt, detect_count); else pass_cnt++;
        bit_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_match();
        test_restart();
        test_mismatch();
        test_gaps();
        test_length_zero_one();
        test_clamp();
        test_saturation_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
